uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - oversampling UART receiver
//
// Receives frames of: start bit (0), DATA_WIDTH data bits LSB first, an
// optional parity bit, then one stop bit (1). Each bit lasts `prescale` clk
// cycles, latched at frame start. The bit value is the majority vote of three
// samples taken around the middle of the bit.
//
// Configuration macro: UART_RX_PARITY_EN
//   defined   -> parity bit supported (par_en / par_typ honoured)
//   undefined -> no parity state or logic, par_en / par_typ ignored,
//                par_err tied low
//
// Parameters:
//   DATA_WIDTH  payload bits per frame (2 or more)
//
// Ports:
//   clk         clock, rising edge active
//   rst         synchronous active-high reset
//   RX_IN       serial line, idle high, already synchronised externally
//   prescale    clk cycles per bit; values below 4 behave as 4
//   par_en      1 = frame carries a parity bit
//   par_typ     0 = even parity, 1 = odd parity
//   P_DATA      payload of the last good frame
//   data_valid  1-cycle pulse, good frame received
//   par_err     1-cycle pulse, parity mismatch
//   stp_err     1-cycle pulse, stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state;
  logic [5:0]             edge_cnt;
  logic [5:0]             presc;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [1:0]             samp;
  logic                   bit_val;
  logic                   par_fail;

`ifdef UART_RX_PARITY_EN
  logic                   par_en_q;
  logic                   par_typ_q;
`else
  // Configuration inputs have no function in this build.
  logic                   unused_cfg;
  assign unused_cfg = par_en ^ par_typ;
  assign par_fail   = 1'b0;
  assign par_err    = 1'b0;
`endif

  logic [5:0] half;
  logic       last_edge;
  logic       sample_bit;

  // Sample points sit at half-1, half and half+1. With prescale 4 the third
  // sample lands on the final edge of the bit, so the vote is formed
  // combinationally from the live line value at that point.
  always_comb begin
    half       = {1'b0, presc[5:1]};
    last_edge  = (edge_cnt == (presc - 6'd1));
    sample_bit = bit_val;
    if (edge_cnt == (half + 6'd1)) begin
      sample_bit = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);
    end
  end

  // Receive FSM; all outputs are registered and pulse in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      edge_cnt   <= 6'd0;
      presc      <= 6'd4;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      samp       <= 2'b00;
      bit_val    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      stp_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err    <= 1'b0;
      par_fail   <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      stp_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state    <= START;
            edge_cnt <= 6'd0;
            presc    <= (prescale < 6'd4) ? 6'd4 : prescale;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_fail  <= 1'b0;
`endif
          end
        end
        default: begin
          if (edge_cnt == (half - 6'd1)) samp[0] <= RX_IN;
          if (edge_cnt == half)          samp[1] <= RX_IN;
          if (edge_cnt == (half + 6'd1)) bit_val <= sample_bit;

          if (last_edge) begin
            edge_cnt <= 6'd0;
            case (state)
              START: begin
                // A start bit that votes high was a glitch on the idle line.
                if (sample_bit) begin
                  state <= IDLE;
                end else begin
                  state   <= DATA;
                  bit_cnt <= '0;
                end
              end
              DATA: begin
                shift_reg <= {sample_bit, shift_reg[DATA_WIDTH-1:1]};
                if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state <= par_en_q ? PARITY : STOP;
`else
                  state <= STOP;
`endif
                end else begin
                  bit_cnt <= bit_cnt + BIT_ONE;
                end
              end
`ifdef UART_RX_PARITY_EN
              PARITY: begin
                par_fail <= (sample_bit != ((^shift_reg) ^ par_typ_q));
                state    <= STOP;
              end
`endif
              STOP: begin
                state   <= IDLE;
                stp_err <= ~sample_bit;
`ifdef UART_RX_PARITY_EN
                par_err <= par_fail;
`endif
                if (sample_bit && !par_fail) begin
                  P_DATA     <= shift_reg;
                  data_valid <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - directed self-checking bench for uart_rx
//
// Drives hand-built serial frames onto RX_IN and checks the registered
// outputs against hand-computed values. A negedge monitor counts output
// pulses so that frame outcomes can be checked as pulse-count deltas.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checkCount   = 0;
  int errorCount   = 0;
  int dvCount      = 0;
  int peCount      = 0;
  int seCount      = 0;
  int overlapCount = 0;
  int dvBase, peBase, seBase;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses away from the active edge; data_valid must never
  // coincide with an error pulse.
  always @(negedge clk) begin
    if (data_valid) dvCount++;
    if (par_err) peCount++;
    if (stp_err) seCount++;
    if (data_valid && (par_err || stp_err)) overlapCount++;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Holds one line level for p clocks; returns 1 ns after the last edge.
  task automatic applyStimulus(input logic level, input int p);
    RX_IN = level;
    repeat (p) @(posedge clk);
    #1;
  endtask

  // Sends one frame. When scramble is set, the configuration inputs are
  // disturbed after the start bit to show they were latched.
  task automatic sendFrame(input logic [7:0] data, input int p,
                           input logic withPar, input logic parBit,
                           input logic stopBit, input logic scramble);
    applyStimulus(1'b0, p);
    if (scramble) begin
      prescale = 6'd3;
      par_en   = 1'b1;
      par_typ  = 1'b1;
    end
    for (int i = 0; i < 8; i++) applyStimulus(data[i], p);
    if (withPar) applyStimulus(parBit, p);
    applyStimulus(stopBit, p);
    RX_IN = 1'b1;
  endtask

  task automatic markCounts();
    dvBase = dvCount;
    peBase = peCount;
    seBase = seCount;
  endtask

  task automatic idleCycles(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    RX_IN    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    checkOutput("reset_pdata", 32'(P_DATA), 32'h00);
    checkOutput("reset_dv", 32'(data_valid), 32'h0);
    checkOutput("reset_pe", 32'(par_err), 32'h0);
    checkOutput("reset_se", 32'(stp_err), 32'h0);
    idleCycles(2);

    // Test 1: prescale 8, no parity, 0x5A; pulse 80 cycles after start edge.
    $display("[TB] test 1: 0x5A at prescale 8");
    markCounts();
    prescale = 6'd8;
    par_en   = 1'b0;
    sendFrame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1_dv_before", 32'(data_valid), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("t1_dv_at80", 32'(data_valid), 32'h1);
    checkOutput("t1_pdata", 32'(P_DATA), 32'h5A);
    idleCycles(4);
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    checkOutput("t1_dv_count", 32'(dvCount - dvBase), 32'd1);
    checkOutput("t1_err_count", 32'((peCount - peBase) + (seCount - seBase)), 32'd0);

    // Test 2: prescale 16, parity enabled, even, 0xA3.
    $display("[TB] test 2: 0xA3 with parity at prescale 16");
    prescale = 6'd16;
    par_en   = 1'b1;
    par_typ  = 1'b0;
    markCounts();
`ifdef UART_RX_PARITY_EN
    sendFrame(8'hA3, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    idleCycles(4);
    checkOutput("t2_good_pdata", 32'(P_DATA), 32'hA3);
    checkOutput("t2_good_dv", 32'(dvCount - dvBase), 32'd1);
    markCounts();
    sendFrame(8'hA3, 16, 1'b1, 1'b1, 1'b1, 1'b0);
    idleCycles(4);
    checkOutput("t2_bad_pe", 32'(peCount - peBase), 32'd1);
    checkOutput("t2_bad_dv", 32'(dvCount - dvBase), 32'd0);
    checkOutput("t2_bad_pdata", 32'(P_DATA), 32'hA3);
`else
    // Without parity support par_en is ignored: the frame has no parity bit.
    sendFrame(8'hA3, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(4);
    checkOutput("t2_nopar_pdata", 32'(P_DATA), 32'hA3);
    checkOutput("t2_nopar_dv", 32'(dvCount - dvBase), 32'd1);
    checkOutput("t2_nopar_pe", 32'(peCount - peBase), 32'd0);
`endif
    par_en = 1'b0;

    // Test 3: stop bit driven low.
    $display("[TB] test 3: 0x3C with bad stop bit");
    prescale = 6'd8;
    markCounts();
    sendFrame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(4);
    checkOutput("t3_se", 32'(seCount - seBase), 32'd1);
    checkOutput("t3_dv", 32'(dvCount - dvBase), 32'd0);
    checkOutput("t3_pdata", 32'(P_DATA), 32'hA3);

    // Test 4: 2-cycle glitch then a valid frame.
    $display("[TB] test 4: glitch then 0x81");
    prescale = 6'd16;
    markCounts();
    applyStimulus(1'b0, 2);
    idleCycles(40);
    checkOutput("t4_glitch_pulses",
                32'((dvCount - dvBase) + (peCount - peBase) + (seCount - seBase)), 32'd0);
    sendFrame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(4);
    checkOutput("t4_pdata", 32'(P_DATA), 32'h81);
    checkOutput("t4_dv", 32'(dvCount - dvBase), 32'd1);

    // Test 5: back-to-back frames at prescale 32.
    $display("[TB] test 5: back-to-back 0x11, 0x22");
    prescale = 6'd32;
    markCounts();
    sendFrame(8'h11, 32, 1'b0, 1'b0, 1'b1, 1'b0);
    sendFrame(8'h22, 32, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(6);
    checkOutput("t5_dv", 32'(dvCount - dvBase), 32'd2);
    checkOutput("t5_pdata", 32'(P_DATA), 32'h22);

    // Prescale below 4 behaves as 4.
    $display("[TB] clamp: 0x96 at prescale 2");
    prescale = 6'd2;
    markCounts();
    sendFrame(8'h96, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(4);
    checkOutput("clamp_pdata", 32'(P_DATA), 32'h96);
    checkOutput("clamp_dv", 32'(dvCount - dvBase), 32'd1);

    // Test 6: reset during bit 4 of 0xFF, then 0x0F.
    $display("[TB] test 6: reset mid-frame");
    prescale = 6'd8;
    markCounts();
    applyStimulus(1'b0, 8);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8);
    applyStimulus(1'b1, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6_rst_pdata", 32'(P_DATA), 32'h00);
    checkOutput("t6_rst_dv", 32'(data_valid), 32'h0);
    checkOutput("t6_rst_pe", 32'(par_err), 32'h0);
    checkOutput("t6_rst_se", 32'(stp_err), 32'h0);
    idleCycles(100);
    checkOutput("t6_abort_pulses",
                32'((dvCount - dvBase) + (peCount - peBase) + (seCount - seBase)), 32'd0);
    checkOutput("t6_abort_pdata", 32'(P_DATA), 32'h00);
    sendFrame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(4);
    checkOutput("t6_pdata", 32'(P_DATA), 32'h0F);
    checkOutput("t6_dv", 32'(dvCount - dvBase), 32'd1);

    checkOutput("no_overlap", 32'(overlapCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
